pattern_gen: RTL and testbench



---
 rtl/pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_pattern_gen.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// pattern_gen: registered, multi-mode VGA test-pattern source.
// It sits between the 640x480 sync counter (hc, vc, vidon) and the 3-3-2 RGB pins.
//
// Modes are stepped by the mode_next pulse:
//   0 HSTRIPE -> 1 VSTRIPE -> 2 CHECKER -> 3 BARS -> 0
//
// A per-frame scroll offset animates the stripe and bar patterns.
// The pause input freezes that offset.
//
// Optional macro PATGEN_BORDER_EN draws a white one-pixel frame
// around the visible area.
//
// Valid/ready: none. All inputs are sampled on every rising clk edge.
// mode_next is a single-cycle pulse. Each cycle it is high advances the mode once.

module pattern_gen #(
    parameter int STRIPE_LOG2 = 4,
    parameter int HPIX_START  = 144,
    parameter int VPIX_START  = 31,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCROLL_STEP = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       vidon,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       mode_next,
    input  logic       pause,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        M_HSTRIPE = 2'd0,
        M_VSTRIPE = 2'd1,
        M_CHECKER = 2'd2,
        M_BARS    = 2'd3
    } mode_t;

`ifdef PATGEN_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    mode_t      mode_q, mode_d;
    logic [9:0] offset_q, offset_d;
    logic       vz_q;
    logic [2:0] red_q, green_q;
    logic [1:0] blue_q;

    logic [9:0] x, y, xs, ys;
    logic       vz, tick, border;
    logic [2:0] pix_r, pix_g;
    logic [1:0] pix_b;
    logic       b;
    logic [2:0] bar_i;

    // Screen coordinates relative to the first visible pixel, plus scrolled copies.
    // All arithmetic is 10-bit and wraps mod 1024.
    always_comb begin
        x      = hc - 10'(HPIX_START);
        y      = vc - 10'(VPIX_START);
        xs     = x + offset_q;
        ys     = y + offset_q;
        vz     = (vc == 10'd0);
        tick   = vz & ~vz_q;
        border = BORDER_EN && ((x == 10'd0) || (x == X_LAST) ||
                               (y == 10'd0) || (y == Y_LAST));
    end

    // Mode FSM next state and scroll offset update.
    // A mode step always restarts the scroll from 0, even when it lands on a frame tick.
    always_comb begin
        mode_d   = mode_q;
        offset_d = offset_q;
        if (mode_next) begin
            mode_d   = mode_t'(mode_q + 2'd1);
            offset_d = 10'd0;
        end else if (tick && !pause) begin
            offset_d = offset_q + 10'(SCROLL_STEP);
        end
    end

    // Pattern colour for the current pixel in the current mode.
    always_comb begin
        pix_r = 3'd0;
        pix_g = 3'd0;
        pix_b = 2'd0;
        b     = 1'b0;
        bar_i = xs[8:6];
        case (mode_q)
            M_HSTRIPE: begin
                b     = ys[STRIPE_LOG2];
                pix_r = {3{b}};
                pix_g = {3{~b}};
            end
            M_VSTRIPE: begin
                b     = xs[STRIPE_LOG2];
                pix_r = {3{b}};
                pix_g = {3{~b}};
            end
            M_CHECKER: begin
                b     = x[STRIPE_LOG2] ^ y[STRIPE_LOG2];
                pix_r = {3{b}};
                pix_g = {3{b}};
                pix_b = {2{b}};
            end
            M_BARS: begin
                pix_r = {3{bar_i[2]}};
                pix_g = {3{bar_i[1]}};
                pix_b = {2{bar_i[0]}};
            end
            default: begin
                pix_r = 3'd0;
            end
        endcase
    end

    // State registers: mode, scroll offset, and the frame-start edge detector.
    // vz_q resets to 1 so that a frame tick cannot fire on the first cycle after reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            mode_q   <= M_HSTRIPE;
            offset_q <= 10'd0;
            vz_q     <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            offset_q <= offset_d;
            vz_q     <= vz;
        end
    end

    // Output register: the pattern and vidon are captured together.
    // This gives one clock of latency from the pixel coordinates to the colour pins.
    always_ff @(posedge clk) begin
        if (clr || !vidon) begin
            red_q   <= 3'd0;
            green_q <= 3'd0;
            blue_q  <= 2'd0;
        end else if (border) begin
            red_q   <= 3'd7;
            green_q <= 3'd7;
            blue_q  <= 2'd3;
        end else begin
            red_q   <= pix_r;
            green_q <= pix_g;
            blue_q  <= pix_b;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign mode  = mode_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed testbench for pattern_gen.
// Each scenario task drives inputs and compares the packed {red,green,blue}
// colour and the mode output against hand-computed values.

module tb_pattern_gen;

    logic       clk;
    logic       clr;
    logic       vidon;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       mode_next;
    logic       pause;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic [1:0] mode;

    int n_vec;
    int n_err;

    pattern_gen dut (
        .clk       (clk),
        .clr       (clr),
        .vidon     (vidon),
        .hc        (hc),
        .vc        (vc),
        .mode_next (mode_next),
        .pause     (pause),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .mode      (mode)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: advance one edge, then settle past it before sampling outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: single-cycle mode_next pulse.
    task automatic pulse_mode();
        mode_next = 1'b1;
        step();
        mode_next = 1'b0;
    endtask

    // Driver: one frame boundary (vc==0 for n cycles), then back to a visible line.
    task automatic frame(input int n);
        vc = 10'd0;
        for (int i = 0; i < n; i++) step();
        vc = 10'd100;
        step();
    endtask

    task automatic test_reset();
        clr = 1'b1; vidon = 1'b1; mode_next = 1'b1; pause = 1'b0;
        hc = 10'd300; vc = 10'd47;
        step();
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rgb: got %h exp %h", {red, green, blue}, 8'h00);
        end
        n_vec++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mode: got %0d exp %0d", mode, 0);
        end
        // Hold vc at 0 across the release: the first cycle after reset must not tick.
        mode_next = 1'b0; vc = 10'd0;
        step();
        clr = 1'b0;
        step();
        vc = 10'd46;                    // y=15: bit4 is 0 with offset 0, but 1 if a tick slipped in
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h1C) begin
            n_err++;
            $display("FAIL reset_no_tick: got %h exp %h", {red, green, blue}, 8'h1C);
        end
    endtask

    task automatic test_hstripe();
        vidon = 1'b1; hc = 10'd300; vc = 10'd47;   // y=16
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hE0) begin
            n_err++;
            $display("FAIL hstripe_y16: got %h exp %h", {red, green, blue}, 8'hE0);
        end
        vc = 10'd31;                    // y=0
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h1C) begin
            n_err++;
            $display("FAIL hstripe_y0: got %h exp %h", {red, green, blue}, 8'h1C);
        end
    endtask

    task automatic test_blanking(input string tag);
        vidon = 1'b0; hc = 10'd300; vc = 10'd200;
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h00) begin
            n_err++;
            $display("FAIL blank_%s: got %h exp %h", tag, {red, green, blue}, 8'h00);
        end
        vidon = 1'b1;
    endtask

    task automatic test_mode_fsm();
        vidon = 1'b1; hc = 10'd300; vc = 10'd100;
        pulse_mode();
        n_vec++;
        if (mode !== 2'd1) begin
            n_err++;
            $display("FAIL mode_1: got %0d exp %0d", mode, 1);
        end
        pulse_mode();
        n_vec++;
        if (mode !== 2'd2) begin
            n_err++;
            $display("FAIL mode_2: got %0d exp %0d", mode, 2);
        end
        hc = 10'd160; vc = 10'd31;      // x=16, y=0
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hFF) begin
            n_err++;
            $display("FAIL checker_x16: got %h exp %h", {red, green, blue}, 8'hFF);
        end
        hc = 10'd176;                   // x=32
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h00) begin
            n_err++;
            $display("FAIL checker_x32: got %h exp %h", {red, green, blue}, 8'h00);
        end
        pulse_mode();
        n_vec++;
        if (mode !== 2'd3) begin
            n_err++;
            $display("FAIL mode_3: got %0d exp %0d", mode, 3);
        end
        test_blanking("bars");
        pulse_mode();
        n_vec++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL mode_wrap: got %0d exp %0d", mode, 0);
        end
    endtask

    task automatic test_scroll();
        vidon = 1'b1; hc = 10'd300; pause = 1'b0;
        frame(1);
        frame(1);
        frame(1);                       // offset 3
        vc = 10'd44;                    // y=13, ys=16
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hE0) begin
            n_err++;
            $display("FAIL scroll3_vc44: got %h exp %h", {red, green, blue}, 8'hE0);
        end
        vc = 10'd43;                    // ys=15
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h1C) begin
            n_err++;
            $display("FAIL scroll3_vc43: got %h exp %h", {red, green, blue}, 8'h1C);
        end
        pause = 1'b1;
        frame(1);
        frame(1);                       // still offset 3
        vc = 10'd44;
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hE0) begin
            n_err++;
            $display("FAIL pause_vc44: got %h exp %h", {red, green, blue}, 8'hE0);
        end
        vc = 10'd43;
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h1C) begin
            n_err++;
            $display("FAIL pause_vc43: got %h exp %h", {red, green, blue}, 8'h1C);
        end
        pause = 1'b0;
        frame(3);                       // a long vc==0 stretch is still one tick: offset 4
        vc = 10'd43;                    // ys=16
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hE0) begin
            n_err++;
            $display("FAIL one_tick_vc43: got %h exp %h", {red, green, blue}, 8'hE0);
        end
        vc = 10'd42;                    // ys=15
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h1C) begin
            n_err++;
            $display("FAIL one_tick_vc42: got %h exp %h", {red, green, blue}, 8'h1C);
        end
        // mode_next on the tick edge: mode 1, offset 0, increment dropped.
        vc = 10'd0; mode_next = 1'b1;
        step();
        mode_next = 1'b0; vc = 10'd100;
        step();
        n_vec++;
        if (mode !== 2'd1) begin
            n_err++;
            $display("FAIL tick_mode: got %0d exp %0d", mode, 1);
        end
        hc = 10'd159;                   // x=15: green with offset 0, red with offset 1
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h1C) begin
            n_err++;
            $display("FAIL tick_clear_x15: got %h exp %h", {red, green, blue}, 8'h1C);
        end
        hc = 10'd160;                   // x=16
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hE0) begin
            n_err++;
            $display("FAIL vstripe_x16: got %h exp %h", {red, green, blue}, 8'hE0);
        end
    endtask

    task automatic test_bars();
        vidon = 1'b1; vc = 10'd100;
        pulse_mode();
        pulse_mode();                   // mode 3, offset 0
        hc = 10'd464;                   // x=320, i=5
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hE3) begin
            n_err++;
            $display("FAIL bars_i5: got %h exp %h", {red, green, blue}, 8'hE3);
        end
        hc = 10'd208;                   // x=64, i=1
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h03) begin
            n_err++;
            $display("FAIL bars_i1: got %h exp %h", {red, green, blue}, 8'h03);
        end
        hc = 10'd655;                   // x=511, i=7
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hFF) begin
            n_err++;
            $display("FAIL bars_i7: got %h exp %h", {red, green, blue}, 8'hFF);
        end
        hc = 10'd656;                   // x=512, wraps to i=0
        step();
        n_vec++;
        if ({red, green, blue} !== 8'h00) begin
            n_err++;
            $display("FAIL bars_wrap: got %h exp %h", {red, green, blue}, 8'h00);
        end
    endtask

    task automatic test_midframe_reset();
        hc = 10'd464; vc = 10'd100; clr = 1'b1;
        step();
        n_vec++;
        if (mode !== 2'd0 || {red, green, blue} !== 8'h00) begin
            n_err++;
            $display("FAIL midframe_reset: got mode %0d rgb %h exp mode 0 rgb 00",
                     mode, {red, green, blue});
        end
        clr = 1'b0; vc = 10'd47;        // HSTRIPE, y=16, offset 0
        step();
        n_vec++;
        if ({red, green, blue} !== 8'hE0) begin
            n_err++;
            $display("FAIL after_reset_hstripe: got %h exp %h", {red, green, blue}, 8'hE0);
        end
    endtask

`ifdef PATGEN_BORDER_EN
    task automatic test_border();
        vidon = 1'b1;
        for (int m = 0; m < 4; m++) begin
            hc = 10'd144; vc = 10'd100; // x=0
            step();
            n_vec++;
            if ({red, green, blue} !== 8'hFF) begin
                n_err++;
                $display("FAIL border_mode%0d: got %h exp %h", m, {red, green, blue}, 8'hFF);
            end
            pulse_mode();
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        clr = 1'b1; vidon = 1'b0; hc = 10'd0; vc = 10'd100; mode_next = 1'b0; pause = 1'b0;
        test_reset();
        test_hstripe();
        test_blanking("hstripe");
        test_mode_fsm();
        test_scroll();
        test_bars();
        test_midframe_reset();
`ifdef PATGEN_BORDER_EN
        test_border();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
